updownstream_limiter: RTL
=========================

Name: updownstream_limiter

Overview:
- Parametrised per-client trade-limit engine; the next generation of the upstream/downstream order path.
- The CPU side programs a per-client maximum. The exchange side streams orders through a valid/ready handshake.
- Each accepted order is filled against the client's remaining budget, and the excess is cancelled. Per-client accumulation, a sticky cancel flag and a global cancelled-volume counter are maintained.
- Generalises the fixed 32-client, 16-bit design to N clients, with configurable widths and a partial-fill mode.

Parameters:
- NUM_CLIENTS, 32, number of clients; ID_W = $clog2(NUM_CLIENTS), minimum 1.
- AMT_W, 16, width of order and limit amounts.
- CNT_W, 32, width of the global cancelled-volume counter.
- PARTIAL_FILL, 0. 0 = an order exceeding the remaining budget is rejected whole. 1 = fill up to the budget and cancel the remainder.

Ports:
- clk  in  1  single clock; all state on its rising edge.
- HRESET  in  1  asynchronous, active-high reset.
- cpu_go  in  1  CPU command strobe, one command per cycle.
- cpu_new_max  in  1  with cpu_go: 1 = write limit; 0 = clear client (accumulator and cancel flag).
- cpu_client_id  in  ID_W  CPU target client.
- cpu_amount  in  AMT_W  new limit value.
- exchange_go  in  1  order valid.
- exchange_ready  out  1  order ready; equals !HRESET && !cpu_go (combinational).
- exchange_client_id  in  ID_W  order client.
- exchange_amount  in  AMT_W  order amount.
- rd_client_id  in  ID_W  readback select.
- rd_accumulated  out  AMT_W  registered accumulated fill of rd_client_id.
- max_to_trade  out  NUM_CLIENTS  bit i = limit[i] > acc[i] (client has budget left).
- cancelled_orders  out  NUM_CLIENTS  sticky bit i = client i has had any volume cancelled.
- cancelled_total  out  CNT_W  saturating sum of all cancelled volume.
- fill_valid  out  1  one-cycle result strobe.
- fill_client_id  out  ID_W  client of the result.
- fill_amount  out  AMT_W  filled volume.
- fill_cancelled  out  AMT_W  cancelled volume.

Behaviour:
- Reset: all limit[], acc[] and cancel bits go to 0. Outputs reset to 0: fill_valid, fill_client_id, fill_amount, fill_cancelled, rd_accumulated, cancelled_total, max_to_trade and cancelled_orders. Reset is asynchronous, so asserting it mid-order drops the result and fill_valid falls immediately.
- Accept: an order is accepted when exchange_go && exchange_ready. The fill_* outputs are registered and valid exactly 1 cycle after acceptance. Back-to-back orders are accepted every cycle.
- Same-client back-to-back orders: the second order sees the first order's updated accumulator, because the array is written at the accepting edge.
- Collision: cpu_go has priority. exchange_ready is low in that cycle, and the exchange must hold its order.
- Budget arithmetic:
  - rem = (limit > acc) ? limit - acc : 0, computed in AMT_W unsigned with no wrap.
  - amt <= rem: fill = amt, cancel = 0.
  - amt > rem, PARTIAL_FILL=1: fill = rem, cancel = amt - rem.
  - amt > rem, PARTIAL_FILL=0: fill = 0, cancel = amt.
  - acc += fill. acc never exceeds limit at the time of the order, so no overflow is possible.
- cancel > 0 sets cancelled_orders[id] and adds cancel to cancelled_total, saturating at all-ones.
- Zero-amount order: fill_valid pulses with fill = 0 and cancel = 0; no state changes.
- Out-of-range id (id >= NUM_CLIENTS, non-power-of-2 N only): full cancel with fill = 0. cancelled_total is updated; no per-client state changes.
- CPU write limit (cpu_new_max=1): limit[id] = cpu_amount, acc is unchanged. Lowering the limit to or below acc makes rem = 0 and clears max_to_trade[id].
- CPU clear (cpu_new_max=0): acc[id] = 0 and cancelled_orders[id] = 0; limit is unchanged.
- CPU commands to an out-of-range id are ignored.
- rd_accumulated <= acc[rd_client_id], sampled before any same-cycle update (1-cycle latency, pre-update value).
- max_to_trade and cancelled_orders are direct decodes of state registers and reflect state after the last edge.

Decomposition:
- Package updownstream_pkg holds:
  - fill_result_t struct (client_id, fill, cancel);
  - function calc_fill(limit, acc, amt, partial) returning fill_result_t;
  - saturating-add function for cancelled_total.
- Natural sub-module: updownstream_client_bank, holding the limit/acc/cancel register arrays with one CPU write port, one order update port and one read port.
- The top level holds the handshake, arithmetic, output registers and counter.

Test Plan:
- Reset, then limit[3]=100; orders id3 amounts 60 then 60 on consecutive cycles, PARTIAL_FILL=0 -> results fill 60/cancel 0, then fill 0/cancel 60; cancelled_orders[3]=1, cancelled_total=60, max_to_trade[3]=1.
- Same stimulus with PARTIAL_FILL=1 -> second result is fill 40/cancel 20; acc[3]=100; max_to_trade[3]=0; cancelled_total=20.
- cpu_go asserted with exchange_go held for id5 amount 10 -> exchange_ready=0 that cycle; order accepted the next cycle; fill_valid one cycle after acceptance.
- limit[7]=50, order 30, then limit[7]=20 -> max_to_trade[7]=0; order 5 -> fill 0, cancel 5; CPU clear id7 -> acc=0, cancelled_orders[7]=0, and an order of 20 fills fully.
- Preload cancelled_total to 2^CNT_W-10, then cancel 25 -> saturates at all-ones.
- HRESET asserted in the cycle after an accept -> fill_valid=0 and all arrays and outputs are 0 without waiting for a clock edge.

Source files
------------

// File: rtl/updownstream_pkg.sv
// Purpose: shared types and arithmetic helpers for the per-client trade-limit engine.
//   fill_result_t : outcome of one order (client, filled volume, cancelled volume)
//   calc_fill     : budget arithmetic for one order against limit/accumulator
//   sat_add       : saturating add for the global cancelled-volume counter
// Field widths are the widest supported; callers zero-extend into them and narrow back.
package updownstream_pkg;

  localparam int unsigned MAX_AMT_W = 32;
  localparam int unsigned MAX_ID_W  = 16;
  localparam int unsigned MAX_CNT_W = 64;

  typedef struct packed {
    logic [MAX_ID_W-1:0]  client_id;
    logic [MAX_AMT_W-1:0] fill;
    logic [MAX_AMT_W-1:0] cancel;
  } fill_result_t;

  // Fill an order against the remaining budget; the remainder is never negative.
  function automatic fill_result_t calc_fill(input logic [MAX_AMT_W-1:0] limit,
                                             input logic [MAX_AMT_W-1:0] acc,
                                             input logic [MAX_AMT_W-1:0] amt,
                                             input logic                 partial);
    fill_result_t         res;
    logic [MAX_AMT_W-1:0] rem;
    res = '0;
    rem = (limit > acc) ? (limit - acc) : '0;
    if (amt <= rem) begin
      res.fill = amt;
    end else if (partial) begin
      res.fill   = rem;
      res.cancel = amt - rem;
    end else begin
      res.cancel = amt;
    end
    return res;
  endfunction

  // cur + add, clamped to the all-ones value of a width-bit counter.
  function automatic logic [MAX_CNT_W-1:0] sat_add(input logic [MAX_CNT_W-1:0] cur,
                                                   input logic [MAX_CNT_W-1:0] add,
                                                   input int unsigned          width);
    logic [MAX_CNT_W:0] sum;
    logic [MAX_CNT_W:0] lim;
    lim = {1'b0, {MAX_CNT_W{1'b1}}} >> (MAX_CNT_W - width);
    sum = {1'b0, cur} + {1'b0, add};
    if (sum > lim) begin
      sum = lim;
    end
    return sum[MAX_CNT_W-1:0];
  endfunction

endpackage

// File: rtl/updownstream_client_bank.sv
// Purpose: per-client state arrays (limit, accumulated fill, sticky cancel flag).
// Ports:
//   clk, rst                       clock, async active-high reset
//   cpu_wr_lim/cpu_wr_clr/cpu_id/cpu_amount   CPU write port (limit write or client clear)
//   upd_en/upd_id/upd_acc/upd_set_cancel      order update port
//   ord_id -> ord_limit_c/ord_acc_c           combinational read for order arithmetic
//   rd_id  -> rd_acc_c                        combinational readback
//   max_to_trade, cancelled_orders            per-client status vectors
// Out-of-range ids are ignored on writes and read back as zero.
module updownstream_client_bank #(
  parameter int unsigned NUM_CLIENTS = 32,
  parameter int unsigned ID_W        = 5,
  parameter int unsigned AMT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_wr_lim,
  input  logic                   cpu_wr_clr,
  input  logic [ID_W-1:0]        cpu_id,
  input  logic [AMT_W-1:0]       cpu_amount,
  input  logic                   upd_en,
  input  logic [ID_W-1:0]        upd_id,
  input  logic [AMT_W-1:0]       upd_acc,
  input  logic                   upd_set_cancel,
  input  logic [ID_W-1:0]        ord_id,
  output logic [AMT_W-1:0]       ord_limit_c,
  output logic [AMT_W-1:0]       ord_acc_c,
  input  logic [ID_W-1:0]        rd_id,
  output logic [AMT_W-1:0]       rd_acc_c,
  output logic [NUM_CLIENTS-1:0] max_to_trade,
  output logic [NUM_CLIENTS-1:0] cancelled_orders
);

  localparam logic [ID_W:0] N_L = (ID_W+1)'(NUM_CLIENTS);

  logic [AMT_W-1:0]       r_limit [NUM_CLIENTS];
  logic [AMT_W-1:0]       r_acc   [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] r_cancel;
  logic                   w_cpu_in;
  logic                   w_upd_in;
  logic                   w_ord_in;
  logic                   w_rd_in;

  assign w_cpu_in = {1'b0, cpu_id} < N_L;
  assign w_upd_in = {1'b0, upd_id} < N_L;
  assign w_ord_in = {1'b0, ord_id} < N_L;
  assign w_rd_in  = {1'b0, rd_id}  < N_L;

  // Limit array: CPU-only writer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CLIENTS); i++) r_limit[i] <= '0;
    end else if (cpu_wr_lim && w_cpu_in) begin
      r_limit[cpu_id] <= cpu_amount;
    end
  end

  // Accumulator and cancel flags; CPU and order updates never share a cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CLIENTS); i++) r_acc[i] <= '0;
      r_cancel <= '0;
    end else if (cpu_wr_clr && w_cpu_in) begin
      r_acc[cpu_id]    <= '0;
      r_cancel[cpu_id] <= 1'b0;
    end else if (upd_en && w_upd_in) begin
      r_acc[upd_id] <= upd_acc;
      if (upd_set_cancel) r_cancel[upd_id] <= 1'b1;
    end
  end

  // Read ports and status decode.
  always_comb begin
    ord_limit_c = w_ord_in ? r_limit[ord_id] : '0;
    ord_acc_c   = w_ord_in ? r_acc[ord_id]   : '0;
    rd_acc_c    = w_rd_in  ? r_acc[rd_id]    : '0;
    for (int i = 0; i < int'(NUM_CLIENTS); i++) begin
      max_to_trade[i] = r_limit[i] > r_acc[i];
    end
  end

  assign cancelled_orders = r_cancel;

endmodule

// File: rtl/updownstream_limiter.sv
// Purpose: per-client trade-limit engine. CPU programs limits / clears clients; the
// exchange streams orders that are filled against the remaining budget, excess cancelled.
// Ports:
//   clk, HRESET                         clock, async active-high reset
//   cpu_go/cpu_new_max/cpu_client_id/cpu_amount   CPU command (priority over orders)
//   exchange_go/exchange_ready/exchange_client_id/exchange_amount   order handshake
//   rd_client_id -> rd_accumulated      registered accumulator readback
//   max_to_trade, cancelled_orders      per-client status
//   cancelled_total                     saturating cancelled volume
//   fill_valid/fill_client_id/fill_amount/fill_cancelled   per-order result strobe
module updownstream_limiter
  import updownstream_pkg::*;
#(
  parameter  int unsigned NUM_CLIENTS  = 32,
  parameter  int unsigned AMT_W        = 16,
  parameter  int unsigned CNT_W        = 32,
  parameter  int unsigned PARTIAL_FILL = 0,
  localparam int unsigned ID_W         = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                   clk,
  input  logic                   HRESET,
  input  logic                   cpu_go,
  input  logic                   cpu_new_max,
  input  logic [ID_W-1:0]        cpu_client_id,
  input  logic [AMT_W-1:0]       cpu_amount,
  input  logic                   exchange_go,
  output logic                   exchange_ready,
  input  logic [ID_W-1:0]        exchange_client_id,
  input  logic [AMT_W-1:0]       exchange_amount,
  input  logic [ID_W-1:0]        rd_client_id,
  output logic [AMT_W-1:0]       rd_accumulated,
  output logic [NUM_CLIENTS-1:0] max_to_trade,
  output logic [NUM_CLIENTS-1:0] cancelled_orders,
  output logic [CNT_W-1:0]       cancelled_total,
  output logic                   fill_valid,
  output logic [ID_W-1:0]        fill_client_id,
  output logic [AMT_W-1:0]       fill_amount,
  output logic [AMT_W-1:0]       fill_cancelled
);

  localparam logic [MAX_AMT_W-1:0] AMT_MAX = MAX_AMT_W'({AMT_W{1'b1}});

  logic             w_accept;
  logic             w_ord_in;
  logic [AMT_W-1:0] w_limit;
  logic [AMT_W-1:0] w_acc;
  logic [AMT_W-1:0] w_rd_acc;
  logic [AMT_W-1:0] w_fill;
  logic [AMT_W-1:0] w_cancel;
  fill_result_t     w_res;

  logic             r_fill_valid;
  logic [ID_W-1:0]  r_fill_id;
  logic [AMT_W-1:0] r_fill_amt;
  logic [AMT_W-1:0] r_fill_cnl;
  logic [AMT_W-1:0] r_rd_acc;
  logic [CNT_W-1:0] r_total;

  // CPU commands win; the exchange holds its order while cpu_go is high.
  assign exchange_ready = !HRESET && !cpu_go;
  assign w_accept       = exchange_go && exchange_ready;

  // Order arithmetic. Inputs are zero-extended, so the clamps never engage.
  always_comb begin
    w_res           = calc_fill(MAX_AMT_W'(w_limit), MAX_AMT_W'(w_acc),
                                MAX_AMT_W'(exchange_amount), PARTIAL_FILL != 0);
    w_res.client_id = MAX_ID_W'(exchange_client_id);
    w_ord_in        = w_res.client_id < MAX_ID_W'(NUM_CLIENTS);
    w_fill          = '0;
    w_cancel        = exchange_amount;
    if (w_ord_in) begin
      w_fill   = (w_res.fill   > AMT_MAX) ? '1 : AMT_W'(w_res.fill);
      w_cancel = (w_res.cancel > AMT_MAX) ? '1 : AMT_W'(w_res.cancel);
    end
  end

  updownstream_client_bank #(
    .NUM_CLIENTS (NUM_CLIENTS),
    .ID_W        (ID_W),
    .AMT_W       (AMT_W)
  ) u_bank (
    .clk              (clk),
    .rst              (HRESET),
    .cpu_wr_lim       (cpu_go && cpu_new_max),
    .cpu_wr_clr       (cpu_go && !cpu_new_max),
    .cpu_id           (cpu_client_id),
    .cpu_amount       (cpu_amount),
    .upd_en           (w_accept && w_ord_in),
    .upd_id           (exchange_client_id),
    .upd_acc          (w_acc + w_fill),
    .upd_set_cancel   (w_cancel != '0),
    .ord_id           (exchange_client_id),
    .ord_limit_c      (w_limit),
    .ord_acc_c        (w_acc),
    .rd_id            (rd_client_id),
    .rd_acc_c         (w_rd_acc),
    .max_to_trade     (max_to_trade),
    .cancelled_orders (cancelled_orders)
  );

  // Result strobe, readback and cancelled-volume counter.
  always_ff @(posedge clk or posedge HRESET) begin
    if (HRESET) begin
      r_fill_valid <= 1'b0;
      r_fill_id    <= '0;
      r_fill_amt   <= '0;
      r_fill_cnl   <= '0;
      r_rd_acc     <= '0;
      r_total      <= '0;
    end else begin
      r_fill_valid <= w_accept;
      r_rd_acc     <= w_rd_acc;
      if (w_accept) begin
        r_fill_id  <= exchange_client_id;
        r_fill_amt <= w_fill;
        r_fill_cnl <= w_cancel;
        if (w_cancel != '0) begin
          r_total <= CNT_W'(sat_add(MAX_CNT_W'(r_total), MAX_CNT_W'(w_cancel), CNT_W));
        end
      end
    end
  end

  assign fill_valid      = r_fill_valid;
  assign fill_client_id  = r_fill_id;
  assign fill_amount     = r_fill_amt;
  assign fill_cancelled  = r_fill_cnl;
  assign rd_accumulated  = r_rd_acc;
  assign cancelled_total = r_total;

endmodule
